// File: rtl/router_pkg.sv
// Shared router types and constants used by the
// output-side switch allocator.
package router_pkg;

    localparam int FLIT_SIZE         = 16;
    localparam int NUM_OF_PORTS      = 5;
    localparam int NUM_OF_PORTS_BITS = $clog2(NUM_OF_PORTS);
    localparam int BUF_DEPTH         = 4;

    typedef logic [FLIT_SIZE-1:0] FLIT_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTING = 2'd1,
        ACTIVE  = 2'd2
    } GLOBAL_STATE_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or
// after the pointer wins, wrapping modulo NUM_INPUTS.
module rr_arbiter #(
    parameter int NUM_INPUTS = 5,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    input  logic                  enable,
    output logic [NUM_INPUTS-1:0] grant,
    output logic [IDX_W-1:0]      index
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            j = (int'(ptr) + i) % NUM_INPUTS;
            if (enable && !found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/output_unit_allocator.sv
// Output-port allocator: grants the port to one input at a time,
// forwards the owner's flits and tracks downstream credits.
module output_unit_allocator
    import router_pkg::*;
#(
    parameter int NUM_INPUTS = 5,
    parameter int FLIT_W     = router_pkg::FLIT_SIZE,
    parameter int BUF_DEPTH  = router_pkg::BUF_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_INPUTS-1:0]        i_switch_req,
    output logic [NUM_INPUTS-1:0]        o_switch_ack,
    input  logic [NUM_INPUTS-1:0]        i_packet_done,
    input  logic [NUM_INPUTS*FLIT_W-1:0] i_flit,
    input  logic                         i_credit,
    output logic [FLIT_W-1:0]            o_flit,
    output logic                         o_flit_valid,
    output logic                         o_stall,
    output GLOBAL_STATE_t                o_state,
    output logic [$clog2(NUM_INPUTS)-1:0] o_owner
);

    localparam int OW = $clog2(NUM_INPUTS);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    GLOBAL_STATE_t state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          pend_q, pend_d;

    logic [FLIT_W-1:0]     flits [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] grant;
    logic [OW-1:0]         win;
    logic                  has_credit;
    logic                  owner_flit_v;
    logic                  arb_en;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_unpack
        assign flits[g] = i_flit[g*FLIT_W +: FLIT_W];
    end

    assign has_credit   = (credits_q != '0);
    assign owner_flit_v = flits[owner_q][FLIT_W-1];
    assign arb_en       = !reset && (state_q == IDLE) && has_credit;

    rr_arbiter #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_W      (OW)
    ) u_arb (
        .req    (i_switch_req),
        .ptr    (rr_ptr_q),
        .enable (arb_en),
        .grant  (grant),
        .index  (win)
    );

    assign o_switch_ack = grant;
    assign o_state      = state_q;
    assign o_owner      = owner_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        pend_d       = pend_q;
        o_flit       = '0;
        o_flit_valid = 1'b0;
        o_stall      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant != '0) begin
                    owner_d = win;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!reset) begin
                    o_flit       = flits[owner_q];
                    o_flit_valid = owner_flit_v && has_credit;
                    o_stall      = owner_flit_v && !has_credit;
                end
                // A stalled tail keeps the grant until it actually leaves.
                if ((i_packet_done[owner_q] || pend_q) && !o_stall) begin
                    state_d  = IDLE;
                    pend_d   = 1'b0;
                    rr_ptr_d = (owner_q == OW'(NUM_INPUTS - 1))
                             ? '0 : owner_q + OW'(1);
                end else if (i_packet_done[owner_q]) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        credits_d = credits_q;
        if (i_credit && !o_flit_valid) begin
            if (credits_q != CW'(BUF_DEPTH))
                credits_d = credits_q + CW'(1);
        end else if (!i_credit && o_flit_valid) begin
            credits_d = credits_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            credits_q <= CW'(BUF_DEPTH);
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            credits_q <= credits_d;
            pend_q    <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && i_credit && !o_flit_valid)
            assert (credits_q != CW'(BUF_DEPTH))
            else $error("credit returned with counter already full");
    end

endmodule

// File: tb/tb_output_unit_allocator.sv
// Scoreboard bench for output_unit_allocator with a
// behavioural reference model of grant, forwarding and credits.
module tb_output_unit_allocator;
    import router_pkg::*;

    localparam int N  = 5;
    localparam int W  = FLIT_SIZE;
    localparam int D  = BUF_DEPTH;
    localparam int OW = $clog2(N);

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        req;
    logic [N-1:0]        ack;
    logic [N-1:0]        done;
    logic [N*W-1:0]      flit_bus;
    logic                credit;
    logic [W-1:0]        o_flit;
    logic                o_flit_valid;
    logic                o_stall;
    GLOBAL_STATE_t       o_state;
    logic [OW-1:0]       o_owner;

    output_unit_allocator #(
        .NUM_INPUTS (N),
        .FLIT_W     (W),
        .BUF_DEPTH  (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_switch_req  (req),
        .o_switch_ack  (ack),
        .i_packet_done (done),
        .i_flit        (flit_bus),
        .i_credit      (credit),
        .o_flit        (o_flit),
        .o_flit_valid  (o_flit_valid),
        .o_stall       (o_stall),
        .o_state       (o_state),
        .o_owner       (o_owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  ack;
        logic [W-1:0]  flit;
        logic          valid;
        logic          stall;
        GLOBAL_STATE_t state;
        int            owner;
    } exp_t;

    exp_t expq[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference model state
    bit m_busy    = 0;
    int m_owner   = 0;
    int m_ptr     = 0;
    int m_credits = D;
    bit m_pend    = 0;

    task automatic step(input logic r, input logic [N-1:0] rq,
                        input logic [N-1:0] dn,
                        input logic [N*W-1:0] fl, input logic cr);
        exp_t      e;
        logic [W-1:0] f;
        bit        c;
        bit        v;
        @(posedge clk);
        #1;
        c = cr && (m_credits < D);
        reset = r; req = rq; done = dn; flit_bus = fl; credit = c;
        e.ack   = '0;
        e.flit  = '0;
        e.valid = 1'b0;
        e.stall = 1'b0;
        e.state = m_busy ? ACTIVE : IDLE;
        e.owner = m_owner;
        if (r) begin
            m_busy = 0; m_owner = 0; m_ptr = 0;
            m_credits = D; m_pend = 0;
        end else if (!m_busy) begin
            if (m_credits > 0) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (rq[idx]) begin
                        e.ack[idx] = 1'b1;
                        m_owner = idx;
                        m_busy  = 1;
                        break;
                    end
                end
            end
            if (c) m_credits++;
        end else begin
            f       = fl[m_owner*W +: W];
            v       = f[W-1];
            e.flit  = f;
            e.valid = v && (m_credits > 0);
            e.stall = v && (m_credits == 0);
            if ((dn[m_owner] || m_pend) && !e.stall) begin
                m_busy = 0;
                m_pend = 0;
                m_ptr  = (m_owner + 1) % N;
            end else if (dn[m_owner]) begin
                m_pend = 1;
            end
            m_credits = m_credits + int'(c) - int'(e.valid);
        end
        expq.push_back(e);
    endtask

    function automatic logic [N*W-1:0] one_flit(int port, bit vld,
                                                 int payload);
        logic [N*W-1:0] b;
        logic [W-1:0]   f;
        b = '0;
        f = W'(payload);
        f[W-1] = vld;
        b[port*W +: W] = f;
        return b;
    endfunction

    function automatic logic [N*W-1:0] rand_flits(int vpct);
        logic [N*W-1:0] b;
        logic [W-1:0]   f;
        b = '0;
        for (int p = 0; p < N; p++) begin
            f = W'($urandom);
            f[W-1] = ($urandom_range(99) < vpct);
            b[p*W +: W] = f;
        end
        return b;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            vectors += 6;
            if (ack !== e.ack) begin
                errors++;
                $display("FAIL ack got %b want %b", ack, e.ack);
            end
            if (o_flit !== e.flit) begin
                errors++;
                $display("FAIL flit got %h want %h", o_flit, e.flit);
            end
            if (o_flit_valid !== e.valid) begin
                errors++;
                $display("FAIL valid got %b want %b",
                         o_flit_valid, e.valid);
            end
            if (o_stall !== e.stall) begin
                errors++;
                $display("FAIL stall got %b want %b", o_stall, e.stall);
            end
            if (o_state !== e.state) begin
                errors++;
                $display("FAIL state got %0d want %0d",
                         o_state, e.state);
            end
            if (int'(o_owner) != e.owner) begin
                errors++;
                $display("FAIL owner got %0d want %0d",
                         o_owner, e.owner);
            end
        end
    end

    initial begin
        reset = 1'b1; req = '0; done = '0;
        flit_bus = '0; credit = 1'b0;

        // Reset, then single request on input 2
        step(1, '0, '0, '0, 0);
        step(1, '0, '0, '0, 0);
        step(0, '0, '0, '0, 0);
        step(0, 5'b00100, '0, '0, 0);
        step(0, '0, '0, one_flit(2, 1, 16'h0123), 0);
        step(0, '0, 5'b00100, one_flit(2, 1, 16'h0456), 0);
        step(0, '0, '0, '0, 1);
        step(0, '0, '0, '0, 1);

        // Contention from a fresh pointer
        step(1, '0, '0, '0, 0);
        step(0, 5'b10011, '0, '0, 0);
        step(0, 5'b10010, 5'b00001, one_flit(0, 1, 16'h0aa), 0);
        step(0, 5'b10010, '0, '0, 0);
        step(0, 5'b10000, 5'b00010, one_flit(1, 1, 16'h0bb), 0);
        step(0, 5'b10000, '0, '0, 0);
        step(0, '0, 5'b10000, one_flit(4, 1, 16'h0cc), 0);

        // Credit exhaustion on input 3, then one credit
        step(1, '0, '0, '0, 0);
        step(0, 5'b01000, '0, '0, 0);
        for (int i = 0; i < 6; i++)
            step(0, '0, '0, one_flit(3, 1, 16'h100 + i), 0);
        step(0, '0, 5'b01000, one_flit(3, 1, 16'h1ff), 1);
        step(0, '0, '0, one_flit(3, 1, 16'h1ff), 0);
        step(0, '0, '0, one_flit(3, 1, 16'h1ff), 1);
        step(0, '0, '0, '0, 1);

        // Stray done and flits from a non-owner
        step(1, '0, '0, '0, 0);
        step(0, 5'b00010, '0, '0, 0);
        step(0, '0, 5'b01000,
             one_flit(1, 1, 16'h011) | one_flit(3, 1, 16'h033), 0);
        step(0, '0, '0,
             one_flit(1, 1, 16'h012) | one_flit(3, 1, 16'h034), 1);
        step(0, '0, 5'b00010, one_flit(1, 1, 16'h013), 1);

        // Reset mid-packet
        step(0, 5'b00001, '0, '0, 1);
        step(0, '0, '0, one_flit(0, 1, 16'h077), 0);
        step(1, '0, '0, one_flit(0, 1, 16'h078), 0);
        step(0, '0, '0, one_flit(0, 1, 16'h079), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] rq;
            logic [N-1:0] dn;
            rq = N'($urandom) & N'($urandom);
            dn = ($urandom_range(7) == 0) ? N'($urandom) : '0;
            step($urandom_range(99) == 0, rq, dn,
                 rand_flits(70), $urandom_range(1) == 1);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
